// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - Shared register offsets, STATUS bit indices and frame state for spi_target
package spi_target_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_FILL   = 2'd2;
    localparam logic [1:0] REG_IRQEN  = 2'd3;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_FULL     = 3;
    localparam int ST_RXOVR       = 4;
    localparam int ST_TXUNDR      = 5;
    localparam int ST_CS_ACTIVE   = 6;
    localparam int ST_TXDROP      = 7;

    typedef enum logic {
        FRAME_IDLE,
        FRAME_ACTIVE
    } frame_state_t;

endpackage

// File: rtl/spi_target_byte_fifo.sv
// rtl/spi_target_byte_fifo.sv - Byte-wide FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [7:0]                 i_din,
    input  logic                       i_pop,
    output logic [7:0]                 o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rp];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Head is read combinationally, so overwriting the head slot on a full push+pop is safe.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wp] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_do_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - Mode-0 SPI target with RX/TX byte FIFOs behind a hub bus port
// Optional interrupt output and IRQ_EN register enabled by SPI_TARGET_IRQ_EN.
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_5000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  FILL_RESET = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        wen,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        active,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
`ifdef SPI_TARGET_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]   r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic         r_sclk_d, r_cs_d;
    logic         w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_mosi;

    frame_state_t r_state, w_state_next;
    logic [2:0]   r_bitcnt;
    logic [7:0]   r_rx_sh, r_tx_sh;
    logic         r_reload;
    logic         w_load_tx, w_shift_rx, w_shift_tx, w_end_frame, w_byte_done;

    logic         w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic         w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [7:0]   w_rx_din, w_rx_dout, w_tx_dout, w_tx_load_byte;
    logic [CW-1:0] w_rx_count, w_tx_count;

    logic [7:0]   r_fill;
    logic         r_rxovr, r_txundr, r_txdrop;
    logic         w_accept, w_wr, w_rd, w_w1c;
    logic [1:0]   w_off;
    logic [7:0]   w_status;
    logic [31:0]  w_rd_val;
    logic         w_unused;

    assign w_unused = ^{addr[1:0], wdata[31:8], wmask[3:1], w_rx_count, w_tx_count};

    // cs_n chain resets low so a master still holding cs_n low after reset is not seen as a new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= 2'b00;
            r_cs_sync   <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
            r_sclk_d    <= r_sclk_sync[1];
            r_cs_d      <= r_cs_sync[1];
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_d;
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_d;
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_d;
    assign w_mosi      = r_mosi_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FRAME_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // cs_n rise has priority over any sclk edge seen in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_load_tx    = 1'b0;
        w_shift_rx   = 1'b0;
        w_shift_tx   = 1'b0;
        w_end_frame  = 1'b0;
        case (r_state)
            FRAME_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = FRAME_ACTIVE;
                    w_load_tx    = 1'b1;
                end
            end
            FRAME_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next = FRAME_IDLE;
                    w_end_frame  = 1'b1;
                end else if (w_sclk_rise) begin
                    w_shift_rx = 1'b1;
                end else if (w_sclk_fall) begin
                    w_load_tx  = r_reload;
                    w_shift_tx = ~r_reload;
                end
            end
            default: w_state_next = FRAME_IDLE;
        endcase
    end

    assign w_byte_done    = w_shift_rx & (r_bitcnt == 3'd7);
    assign w_rx_din       = {r_rx_sh[6:0], w_mosi};
    assign w_rx_push      = w_byte_done;
    assign w_tx_pop       = w_load_tx & ~w_tx_empty;
    assign w_tx_load_byte = w_tx_empty ? r_fill : w_tx_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitcnt    <= 3'd0;
            r_rx_sh     <= 8'h00;
            r_tx_sh     <= 8'h00;
            r_reload    <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else if (w_end_frame) begin
            r_bitcnt    <= 3'd0;
            r_reload    <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else if (w_load_tx) begin
            r_tx_sh     <= w_tx_load_byte;
            spi_miso    <= w_tx_load_byte[7];
            spi_miso_oe <= 1'b1;
            r_reload    <= 1'b0;
        end else if (w_shift_tx) begin
            r_tx_sh  <= {r_tx_sh[6:0], 1'b0};
            spi_miso <= r_tx_sh[6];
        end else if (w_shift_rx) begin
            r_rx_sh <= w_rx_din;
            if (w_byte_done) begin
                r_bitcnt <= 3'd0;
                r_reload <= 1'b1;
            end else begin
                r_bitcnt <= r_bitcnt + 3'd1;
            end
        end
    end

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_din   (w_rx_din),
        .i_pop   (w_rx_pop),
        .o_dout  (w_rx_dout),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_din   (wdata[7:0]),
        .i_pop   (w_tx_pop),
        .o_dout  (w_tx_dout),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    assign active    = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_off     = addr[3:2];
    assign w_accept  = (wen | ren) & active & ~ready;
    assign w_wr      = w_accept & wen;
    assign w_rd      = w_accept & ren;
    assign w_w1c     = w_wr & (w_off == REG_STATUS) & wmask[0];
    assign w_rx_pop  = w_rd & (w_off == REG_DATA) & ~w_rx_empty;
    assign w_tx_push = w_wr & (w_off == REG_DATA) & wmask[0];

    always_comb begin
        w_status                 = 8'h00;
        w_status[ST_RX_NONEMPTY] = ~w_rx_empty;
        w_status[ST_RX_FULL]     = w_rx_full;
        w_status[ST_TX_EMPTY]    = w_tx_empty;
        w_status[ST_TX_FULL]     = w_tx_full;
        w_status[ST_RXOVR]       = r_rxovr;
        w_status[ST_TXUNDR]      = r_txundr;
        w_status[ST_CS_ACTIVE]   = (r_state == FRAME_ACTIVE);
        w_status[ST_TXDROP]      = r_txdrop;
    end

`ifdef SPI_TARGET_IRQ_EN
    logic [2:0] r_irq_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_en <= 3'b000;
            irq      <= 1'b0;
        end else begin
            if (w_wr && (w_off == REG_IRQEN) && wmask[0]) begin
                r_irq_en <= wdata[2:0];
            end
            irq <= |(r_irq_en & {r_rxovr | r_txundr | r_txdrop, w_tx_empty, ~w_rx_empty});
        end
    end
`endif

    always_comb begin
        w_rd_val = 32'h0;
        case (w_off)
            REG_DATA:   w_rd_val[7:0] = w_rx_empty ? 8'h00 : w_rx_dout;
            REG_STATUS: w_rd_val[7:0] = w_status;
            REG_FILL:   w_rd_val[7:0] = r_fill;
            REG_IRQEN: begin
`ifdef SPI_TARGET_IRQ_EN
                w_rd_val[2:0] = r_irq_en;
`endif
            end
            default:    w_rd_val = 32'h0;
        endcase
    end

    // Sticky flags: a set in the same cycle as a W1C wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata    <= 32'h0;
            ready    <= 1'b0;
            r_fill   <= FILL_RESET;
            r_rxovr  <= 1'b0;
            r_txundr <= 1'b0;
            r_txdrop <= 1'b0;
        end else begin
            ready <= w_accept;
            rdata <= w_rd ? w_rd_val : 32'h0;
            if (w_wr && (w_off == REG_FILL) && wmask[0]) begin
                r_fill <= wdata[7:0];
            end
            r_rxovr  <= (w_rx_push & w_rx_full & ~w_rx_pop)
                        | (r_rxovr & ~(w_w1c & wdata[ST_RXOVR]));
            r_txundr <= (w_load_tx & w_tx_empty)
                        | (r_txundr & ~(w_w1c & wdata[ST_TXUNDR]));
            r_txdrop <= (w_tx_push & w_tx_full & ~w_tx_pop)
                        | (r_txdrop & ~(w_w1c & wdata[ST_TXDROP]));
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - Scoreboard bench for spi_target: bus reads and MISO bytes checked by monitors
module tb_spi_target;

    localparam logic [31:0] BASE = 32'h0000_5000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = BASE;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wmask = 4'h0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic        active;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
`ifdef SPI_TARGET_IRQ_EN
    logic        irq;
`endif

    spi_target dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .wdata       (wdata),
        .wmask       (wmask),
        .wen         (wen),
        .ren         (ren),
        .rdata       (rdata),
        .ready       (ready),
        .active      (active),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe)
`ifdef SPI_TARGET_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t       bus_q[$];
    logic [7:0] miso_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus monitor: every completion pops one expectation; reads compare rdata.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready) begin
                if (bus_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL bus_unexpected_ready: got rdata 0x%08h expected no response", rdata);
                end else begin
                    e = bus_q.pop_front();
                    if (e.chk) check(e.name, rdata, e.val);
                end
            end
        end
    end

    // MISO monitor: assembles bytes on sclk rise; a cs_n rise discards a partial byte.
    initial begin
        logic [7:0] msh;
        int         mcnt;
        msh  = 8'h00;
        mcnt = 0;
        forever begin
            @(posedge spi_sclk or posedge spi_cs_n);
            if (spi_cs_n) begin
                mcnt = 0;
            end else begin
                msh = {msh[6:0], spi_miso};
                mcnt++;
                if (mcnt == 8) begin
                    mcnt = 0;
                    if (miso_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL miso_unexpected_byte: got 0x%02h expected none", msh);
                    end else begin
                        check("miso_byte", {24'h0, msh}, {24'h0, miso_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic bus(input bit wr, input logic [3:0] off, input logic [31:0] wd,
                       input logic [31:0] expv, input string name);
        exp_t e;
        bit   got;
        e.chk  = !wr;
        e.val  = expv;
        e.name = name;
        bus_q.push_back(e);
        @(posedge clk);
        #1;
        addr  = BASE + {28'h0, off};
        wdata = wd;
        wmask = 4'hF;
        wen   = wr;
        ren   = !wr;
        got   = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ready) got = 1'b1;
        end
        wen = 1'b0;
        ren = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL bus_timeout_%s: got no ready expected ready within 20 clk", name);
            void'(bus_q.pop_back());
        end
    endtask

    task automatic wr(input logic [3:0] off, input logic [7:0] d);
        bus(1'b1, off, {24'h0, d}, 32'h0, "write");
    endtask

    task automatic rd(input logic [3:0] off, input logic [7:0] expv, input string name);
        bus(1'b0, off, 32'h0, {24'h0, expv}, name);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        #100;
    endtask

    task automatic cs_high();
        #100;
        spi_cs_n = 1'b1;
        #100;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            #50 spi_sclk = 1'b1;
            #50 spi_sclk = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_cnt;
        #25 rst = 1'b0;
        #1;
        check("reset_ready", {31'h0, ready}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_miso", {31'h0, spi_miso}, 32'h0);
        check("reset_miso_oe", {31'h0, spi_miso_oe}, 32'h0);
        rd(4'h4, 8'h04, "reset_status");
        rd(4'h8, 8'hFF, "reset_fill");
        rd(4'h0, 8'h00, "reset_data_empty");
`ifndef SPI_TARGET_IRQ_EN
        wr(4'hC, 8'h07);
        rd(4'hC, 8'h00, "reserved_reads_zero");
`endif

        // Inactive address: no response.
        @(posedge clk);
        #1;
        addr = BASE + 32'h10;
        ren  = 1'b1;
        #1;
        check("inactive_active", {31'h0, active}, 32'h0);
        rdy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (ready) rdy_cnt++;
        end
        ren = 1'b0;
        check("inactive_no_ready", rdy_cnt, 0);

        // Two queued TX bytes go out while two RX bytes arrive.
        wr(4'h0, 8'hA5);
        wr(4'h0, 8'h3C);
        rd(4'h4, 8'h00, "t1_status_pre");
        miso_q.push_back(8'hA5);
        miso_q.push_back(8'h3C);
        cs_low();
        check("t1_miso_oe", {31'h0, spi_miso_oe}, 32'h1);
        spi_bits(8'h11, 8);
        spi_bits(8'h22, 8);
        cs_high();
        check("t1_miso_oe_off", {31'h0, spi_miso_oe}, 32'h0);
        rd(4'h4, 8'h25, "t1_status_post");
        rd(4'h0, 8'h11, "t1_data0");
        rd(4'h0, 8'h22, "t1_data1");
        rd(4'h0, 8'h00, "t1_data_empty");
        wr(4'h4, 8'h20);
        rd(4'h4, 8'h04, "t1_status_clr");

        // Underrun sends FILL.
        wr(4'h8, 8'h5A);
        rd(4'h8, 8'h5A, "t2_fill");
        miso_q.push_back(8'h5A);
        cs_low();
        spi_bits(8'hC3, 8);
        cs_high();
        rd(4'h4, 8'h25, "t2_status_undr");
        wr(4'h4, 8'h20);
        rd(4'h4, 8'h05, "t2_status_w1c");
        rd(4'h0, 8'hC3, "t2_data");
        rd(4'h4, 8'h04, "t2_status_end");

        // RX overflow: five bytes, no CPU reads.
        for (int i = 0; i < 5; i++) miso_q.push_back(8'h5A);
        cs_low();
        for (int i = 1; i <= 5; i++) spi_bits(8'(i), 8);
        cs_high();
        rd(4'h4, 8'h37, "t3_status_ovr");
        rd(4'h0, 8'h01, "t3_data0");
        rd(4'h0, 8'h02, "t3_data1");
        rd(4'h0, 8'h03, "t3_data2");
        rd(4'h0, 8'h04, "t3_data3");
        rd(4'h0, 8'h00, "t3_data_empty");
        wr(4'h4, 8'hB0);
        rd(4'h4, 8'h04, "t3_status_clr");

        // Aborted partial frame, then a full frame.
        cs_low();
        spi_bits(8'hA0, 3);
        cs_high();
        miso_q.push_back(8'h5A);
        cs_low();
        spi_bits(8'h81, 8);
        cs_high();
        rd(4'h0, 8'h81, "t4_data");
        rd(4'h0, 8'h00, "t4_data_empty");
        wr(4'h4, 8'h20);

        // TX overflow, then reset mid-frame.
        for (int i = 0; i < 5; i++) wr(4'h0, 8'(8'h10 + i));
        rd(4'h4, 8'h88, "t5_status_drop");
        cs_low();
        spi_bits(8'hFF, 3);
        check("t5_oe_midframe", {31'h0, spi_miso_oe}, 32'h1);
        rst = 1'b1;
        #1;
        check("t5_oe_in_reset", {31'h0, spi_miso_oe}, 32'h0);
        check("t5_miso_in_reset", {31'h0, spi_miso}, 32'h0);
        #20 rst = 1'b0;
        #100;
        check("t5_oe_after_reset", {31'h0, spi_miso_oe}, 32'h0);
        rd(4'h4, 8'h04, "t5_status_reset");
        cs_high();
        rd(4'h4, 8'h04, "t5_status_idle");
        rd(4'h8, 8'hFF, "t5_fill_reset");

`ifdef SPI_TARGET_IRQ_EN
        begin
            bit seen;
            wr(4'hC, 8'h01);
            rd(4'hC, 8'h01, "irq_en_rb");
            check("irq_idle", {31'h0, irq}, 32'h0);
            miso_q.push_back(8'hFF);
            cs_low();
            spi_bits(8'h77, 7);
            spi_mosi = 1'b1;
            #50 spi_sclk = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 4 && !seen; i++) begin
                @(posedge clk);
                #1;
                if (irq) seen = 1'b1;
            end
            check("irq_after_byte", {31'h0, seen}, 32'h1);
            #20 spi_sclk = 1'b0;
            cs_high();
            rd(4'h0, 8'h77, "irq_data");
            repeat (3) @(posedge clk);
            #1;
            check("irq_cleared", {31'h0, irq}, 32'h0);
        end
`endif

        repeat (5) @(posedge clk);
        check("bus_queue_drained", bus_q.size(), 0);
        check("miso_queue_drained", miso_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
